// File: rtl/trigger_conditioner.sv
// Conditions an asynchronous external trigger into a clean single-cycle pulse:
// synchronizer, glitch filter, edge select, arm/single-shot policy, holdoff.
module trigger_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 8,
  parameter int HOLDOFF_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 trig_in,
  input  logic                 enable,
  input  logic                 single_shot,
  input  logic                 arm,
  input  logic [1:0]           edge_sel,
  input  logic [FILTER_W-1:0]  filter_cycles,
  input  logic [HOLDOFF_W-1:0] holdoff_cycles,
  input  logic                 clear_counts,
  output logic                 trigger,
  output logic                 armed,
  output logic                 in_holdoff,
  output logic [15:0]          trig_count,
  output logic [7:0]           missed_count,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam int ST_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ST_W-1:0] ST_DONE = ST_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [ST_W-1:0]        start_cnt_q, start_cnt_d;
  logic                   filt_q, filt_d;
  logic                   dly_q, dly_d;
  logic [FILTER_W-1:0]    fcnt_q, fcnt_d;
  state_t                 state_q, state_d;
  logic [HOLDOFF_W-1:0]   hold_q, hold_d;
  logic                   trigger_q, trigger_d;
  logic                   armed_q, armed_d;
  logic                   in_holdoff_q, in_holdoff_d;
  logic [15:0]            trig_count_q, trig_count_d;
  logic [7:0]             missed_q, missed_d;

  logic sync;
  logic startup;
  logic rise;
  logic fall;
  logic edge_det;
  logic fire;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign startup = (start_cnt_q != ST_DONE);

  // Synchronizer, startup window and glitch filter.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], trig_in};
    start_cnt_d = startup ? start_cnt_q + ST_W'(1) : start_cnt_q;
    filt_d      = filt_q;
    dly_d       = filt_q;
    fcnt_d      = '0;
    if (startup) begin
      // Load both copies so the level present at reset is never seen as an edge.
      filt_d = sync;
      dly_d  = sync;
    end else if (sync != filt_q) begin
      if (fcnt_q >= filter_cycles) begin
        filt_d = sync;
      end else begin
        fcnt_d = fcnt_q + FILTER_W'(1);
      end
    end
  end

  always_comb begin
    rise     = filt_q & ~dly_q;
    fall     = ~filt_q & dly_q;
    edge_det = 1'b0;
    case (edge_sel)
      2'b00:   edge_det = rise;
      2'b01:   edge_det = fall;
      2'b10:   edge_det = rise | fall;
      default: edge_det = 1'b0;
    endcase
    edge_det = edge_det & ~startup;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic; dropping enable wins over everything, including a firing edge.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    fire    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!single_shot || arm) state_d = ARMED;
        end
        ARMED: begin
          if (edge_det) begin
            fire    = 1'b1;
            hold_d  = holdoff_cycles;
            state_d = HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (hold_q == '0) begin
            state_d = single_shot ? IDLE : ARMED;
          end else begin
            hold_d = hold_q - HOLDOFF_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Output logic: status flags are registered from the next state so they align with state_q.
  always_comb begin
    trigger_d    = fire;
    armed_d      = (state_d == ARMED);
    in_holdoff_d = (state_d == HOLDOFF);
    trig_count_d = trig_count_q;
    missed_d     = missed_q;
    if (clear_counts) begin
      trig_count_d = '0;
      missed_d     = '0;
    end else begin
      if (fire) trig_count_d = trig_count_q + 16'd1;
      if ((state_q == HOLDOFF) && edge_det && (missed_q != 8'hFF)) begin
        missed_d = missed_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q       <= '0;
      start_cnt_q  <= '0;
      filt_q       <= 1'b0;
      dly_q        <= 1'b0;
      fcnt_q       <= '0;
      trigger_q    <= 1'b0;
      armed_q      <= 1'b0;
      in_holdoff_q <= 1'b0;
      trig_count_q <= '0;
      missed_q     <= '0;
    end else begin
      sync_q       <= sync_d;
      start_cnt_q  <= start_cnt_d;
      filt_q       <= filt_d;
      dly_q        <= dly_d;
      fcnt_q       <= fcnt_d;
      trigger_q    <= trigger_d;
      armed_q      <= armed_d;
      in_holdoff_q <= in_holdoff_d;
      trig_count_q <= trig_count_d;
      missed_q     <= missed_d;
    end
  end

  assign trigger      = trigger_q;
  assign armed        = armed_q;
  assign in_holdoff   = in_holdoff_q;
  assign trig_count   = trig_count_q;
  assign missed_count = missed_q;
  assign state_dbg    = state_q;

endmodule

// File: doc/trigger_conditioner.md
# trigger_conditioner

Conditions an asynchronous external trigger input into the clean, single-cycle `trigger` pulse consumed by the downstream trigger-to-pulse state machine. It applies, in order:
- a synchronizer;
- a programmable glitch filter;
- edge selection;
- an arm / single-shot policy;
- a programmable holdoff.

It also keeps fired and missed trigger counters for status readout.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth (≥2).
- `FILTER_W`, default 8: width of `filter_cycles`.
- `HOLDOFF_W`, default 16: width of `holdoff_cycles`.

Ports:
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset. Asserting it (low) immediately forces all registers to reset values; release is sampled on `clock`.
- `trig_in`  in  1  asynchronous external trigger level.
- `enable`  in  1  block enable; low forces IDLE.
- `single_shot`  in  1  1: re-arm only via `arm`; 0: continuous re-arm.
- `arm`  in  1  single-cycle arm request (used when `single_shot`=1).
- `edge_sel`  in  2  00 rising, 01 falling, 10 both, 11 none.
- `filter_cycles`  in  FILTER_W  glitch-filter length F.
- `holdoff_cycles`  in  HOLDOFF_W  holdoff length H.
- `clear_counts`  in  1  single-cycle clear of both counters.
- `trigger`  out  1  single-cycle conditioned trigger pulse, registered.
- `armed`  out  1  high in ARMED.
- `in_holdoff`  out  1  high in HOLDOFF.
- `trig_count`  out  16  triggers fired; wraps 0xFFFF→0.
- `missed_count`  out  8  qualifying edges seen during HOLDOFF; saturates at 255.

## Operation
- **Reset values:** `trigger`=0, `armed`=0, `in_holdoff`=0, `trig_count`=0, `missed_count`=0, state=IDLE, synchronizer/filter/edge registers=0, filter counter=0, holdoff counter=0.
- **Synchronizer:** `trig_in` passes through a `SYNC_STAGES` flop chain to give `sync`.
- **Startup:** for the first `SYNC_STAGES`+1 edges after reset release, `filt` loads `sync` directly and no edge is reported. A `trig_in` already high at reset therefore produces no trigger.
- **Glitch filter:**
  - While `sync`≠`filt`, the filter counter increments.
  - On the edge where `sync`≠`filt` and the counter equals F, `filt`<=`sync` and the counter clears.
  - Whenever `sync`==`filt`, the counter clears.
  - F=0 means `filt` follows `sync` with one cycle of delay.
- **Edge detect:** `edge_det` is combinational from `filt` versus its one-cycle delayed copy, qualified by `edge_sel`. With `edge_sel`=11, no edges are detected and none are counted.
- **State machine** (IDLE, ARMED, HOLDOFF):
  - IDLE→ARMED when `enable` and (`single_shot`=0 or `arm`). An edge in IDLE is ignored and not counted; `arm` coincident with an edge arms only.
  - ARMED & `edge_det` → `trigger`<=1, `trig_count`++, holdoff counter<=H, state<=HOLDOFF.
  - HOLDOFF: if the counter is 0, go to ARMED when `single_shot`=0, or to IDLE when `single_shot`=1. Otherwise decrement the counter. `edge_det` in HOLDOFF → `missed_count`++ (saturating).
  - `enable` low in any state → IDLE on the next edge. This also clears the holdoff counter and suppresses any coincident trigger.
  - `arm` outside IDLE is ignored.
- **Counters:** `clear_counts` has priority over a coincident increment, so the result is 0. Counters are unaffected by `enable`.
- **Configuration sampling:** `filter_cycles`, `holdoff_cycles` and `edge_sel` are sampled live. Changes mid-filter or mid-holdoff take effect on the next comparison or load.

## Timing
- **Latency:** `trig_in` first sampled high at edge 1 → `trigger` high for exactly one cycle after edge `SYNC_STAGES`+F+2. With the defaults and F=0, that is after edge 4.
- **Minimum filtered pulse:** a `sync` level must persist F+1 consecutive cycles to change `filt`.
- **HOLDOFF duration:** H+1 cycles.
- **Minimum trigger-to-trigger spacing:** H+2 cycles.
- **Status timing:** `armed` and `in_holdoff` are registered and track the state with zero extra delay.
- **Asynchronous reset** mid-holdoff or mid-filter aborts immediately. No `trigger` is emitted during or directly after reset.

## Test plan
- **Basic rise:** defaults, F=0, H=0, continuous, `edge_sel`=00; 10-cycle `trig_in` pulse → one `trigger` pulse after edge 4, `trig_count`=1; the falling edge produces nothing.
- **Filter:** F=3; 3-cycle glitch → no trigger, `trig_count`=0. A 4-cycle pulse → trigger 7 cycles after first sample.
- **Holdoff:** H=10, `edge_sel`=10, filtered rise then fall 5 cycles apart → 1 trigger, `missed_count`=1. Spacing the edges 12 cycles apart → 2 triggers.
- **Single-shot:** `single_shot`=1, no `arm` → edges ignored, `missed_count`=0. Pulse `arm`, two edges 50 cycles apart → 1 trigger, then state returns to IDLE (`armed`=0).
- **Enable / clear:** drop `enable` on the cycle `edge_det` fires → no trigger, state IDLE. Assert `clear_counts` coincident with a trigger → `trig_count`=0. Drive 300 missed edges → `missed_count`=255.
- **Reset:** `trig_in` held high through reset release → no trigger. Assert `reset` low mid-HOLDOFF → all outputs 0 immediately; after release the block re-arms and fires normally.
